// File: rtl/vsfx_pkg.sv
// Shared definitions for the VSFX saturating vector add/sub unit.
// Element-size encodings, per-width clamp constants and the mode bundle.
package vsfx_pkg;

  localparam logic [1:0] VSFX_ESZ_B = 2'd0;
  localparam logic [1:0] VSFX_ESZ_H = 2'd1;
  localparam logic [1:0] VSFX_ESZ_W = 2'd2;

  localparam logic [7:0]  VSFX_SMAX_B = 8'h7F;
  localparam logic [7:0]  VSFX_SMIN_B = 8'h80;
  localparam logic [7:0]  VSFX_UMAX_B = 8'hFF;
  localparam logic [15:0] VSFX_SMAX_H = 16'h7FFF;
  localparam logic [15:0] VSFX_SMIN_H = 16'h8000;
  localparam logic [15:0] VSFX_UMAX_H = 16'hFFFF;
  localparam logic [31:0] VSFX_SMAX_W = 32'h7FFF_FFFF;
  localparam logic [31:0] VSFX_SMIN_W = 32'h8000_0000;
  localparam logic [31:0] VSFX_UMAX_W = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [1:0] esz;
    logic       sgn;
    logic       sub;
  } vsfx_mode_t;

  // Reserved encoding 3 folds onto word.
  function automatic logic [1:0] vsfx_esz_norm(input logic [1:0] esz);
    return (esz == 2'd3) ? VSFX_ESZ_W : esz;
  endfunction

endpackage

// File: rtl/vsfx_sat_lane32.sv
// One 32-bit slice: segmented byte-carry add/sub with overflow
// detection and clamping for byte, halfword and word elements.
module vsfx_sat_lane32
  import vsfx_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  vsfx_mode_t  mode,
  output logic [31:0] res,
  output logic [3:0]  sat
);

  logic [1:0]  esz;
  logic [31:0] bx;
  logic [31:0] sum;
  logic [31:0] smax;
  logic [31:0] smin;
  logic [31:0] umax;
  logic [31:0] clamp;
  logic [3:0]  lsb;
  logic [3:0]  cout;
  logic [3:0]  eov;
  logic [3:0]  eneg;
  logic [3:0]  ovf;
  logic [3:0]  neg;
  logic        cy;
  logic [8:0]  s9;

  always_comb begin
    esz  = vsfx_esz_norm(mode.esz);
    bx   = b ^ {32{mode.sub}};
    lsb  = 4'b0001;
    smax = VSFX_SMAX_W;
    smin = VSFX_SMIN_W;
    umax = VSFX_UMAX_W;
    unique case (esz)
      VSFX_ESZ_B: begin
        lsb  = 4'b1111;
        smax = {4{VSFX_SMAX_B}};
        smin = {4{VSFX_SMIN_B}};
        umax = {4{VSFX_UMAX_B}};
      end
      VSFX_ESZ_H: begin
        lsb  = 4'b0101;
        smax = {2{VSFX_SMAX_H}};
        smin = {2{VSFX_SMIN_H}};
        umax = {2{VSFX_UMAX_H}};
      end
      default: begin
        lsb  = 4'b0001;
        smax = VSFX_SMAX_W;
        smin = VSFX_SMIN_W;
        umax = VSFX_UMAX_W;
      end
    endcase
  end

  // Element-LSB bytes take the subtract carry-in; others chain.
  always_comb begin
    cy   = 1'b0;
    s9   = '0;
    sum  = '0;
    cout = '0;
    for (int i = 0; i < 4; i++) begin
      if (lsb[i]) cy = mode.sub;
      s9 = {1'b0, a[8*i+:8]} + {1'b0, bx[8*i+:8]} + {8'd0, cy};
      sum[8*i+:8] = s9[7:0];
      cout[i]     = s9[8];
      cy          = s9[8];
    end
  end

  always_comb begin
    eov  = '0;
    eneg = '0;
    for (int i = 0; i < 4; i++) begin
      eneg[i] = a[8*i+7];
      if (mode.sgn)
        eov[i] = (a[8*i+7] == bx[8*i+7]) && (sum[8*i+7] != a[8*i+7]);
      else
        eov[i] = cout[i] ^ mode.sub;
    end
  end

  // Broadcast each element's top-byte verdict to all of its bytes.
  always_comb begin
    ovf = eov;
    neg = eneg;
    unique case (esz)
      VSFX_ESZ_B: begin
        ovf = eov;
        neg = eneg;
      end
      VSFX_ESZ_H: begin
        ovf = {eov[3], eov[3], eov[1], eov[1]};
        neg = {eneg[3], eneg[3], eneg[1], eneg[1]};
      end
      default: begin
        ovf = {4{eov[3]}};
        neg = {4{eneg[3]}};
      end
    endcase
  end

  always_comb begin
    clamp = '0;
    res   = '0;
    for (int i = 0; i < 4; i++) begin
      if (mode.sgn)
        clamp[8*i+:8] = neg[i] ? smin[8*i+:8] : smax[8*i+:8];
      else
        clamp[8*i+:8] = mode.sub ? 8'h00 : umax[8*i+:8];
      res[8*i+:8] = ovf[i] ? clamp[8*i+:8] : sum[8*i+:8];
    end
    sat = ovf;
  end

endmodule

// File: rtl/vsfx_vadds_pipe.sv
// Two-stage saturating vector add/sub with per-byte sat flags
// and a sticky SAT bit feeding VSCR[SAT].
module vsfx_vadds_pipe
  import vsfx_pkg::*;
#(
  parameter int VEC_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VEC_W-1:0]   in_vra,
  input  logic [VEC_W-1:0]   in_vrb,
  input  logic [1:0]         in_esz,
  input  logic               in_sgn,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VEC_W-1:0]   out_vrt,
  output logic [VEC_W/8-1:0] out_lane_sat,
  output logic               out_sat,
  input  logic               sat_clr,
  output logic               sat_sticky
);

  localparam int NLANE_B = VEC_W / 8;
  localparam int NSLICE  = VEC_W / 32;

  logic               adv;
  logic               hs;
  logic               s1_valid_q, s1_valid_d;
  logic [VEC_W-1:0]   s1_a_q, s1_a_d;
  logic [VEC_W-1:0]   s1_b_q, s1_b_d;
  vsfx_mode_t         s1_mode_q, s1_mode_d;
  logic               out_valid_q, out_valid_d;
  logic [VEC_W-1:0]   out_vrt_q, out_vrt_d;
  logic [NLANE_B-1:0] out_lane_sat_q, out_lane_sat_d;
  logic               out_sat_q, out_sat_d;
  logic               sat_q, sat_d;
  logic [VEC_W-1:0]   res_c;
  logic [NLANE_B-1:0] lsat_c;

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    vsfx_sat_lane32 u_lane (
      .a    (s1_a_q[32*g+:32]),
      .b    (s1_b_q[32*g+:32]),
      .mode (s1_mode_q),
      .res  (res_c[32*g+:32]),
      .sat  (lsat_c[4*g+:4])
    );
  end

  always_comb begin
    adv            = !out_valid_q | out_ready;
    hs             = out_valid_q & out_ready;
    s1_valid_d     = s1_valid_q;
    s1_a_d         = s1_a_q;
    s1_b_d         = s1_b_q;
    s1_mode_d      = s1_mode_q;
    out_valid_d    = out_valid_q;
    out_vrt_d      = out_vrt_q;
    out_lane_sat_d = out_lane_sat_q;
    out_sat_d      = out_sat_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_a_d        = in_vra;
        s1_b_d        = in_vrb;
        s1_mode_d.esz = in_esz;
        s1_mode_d.sgn = in_sgn;
        s1_mode_d.sub = in_sub;
      end
      if (s1_valid_q) begin
        out_vrt_d      = res_c;
        out_lane_sat_d = lsat_c;
        out_sat_d      = |lsat_c;
      end
    end
    // A saturating handshake beats a same-cycle clear.
    sat_d = (hs & out_sat_q) | (sat_q & !sat_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s1_mode_q      <= '0;
      out_valid_q    <= 1'b0;
      out_vrt_q      <= '0;
      out_lane_sat_q <= '0;
      out_sat_q      <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_a_q         <= s1_a_d;
      s1_b_q         <= s1_b_d;
      s1_mode_q      <= s1_mode_d;
      out_valid_q    <= out_valid_d;
      out_vrt_q      <= out_vrt_d;
      out_lane_sat_q <= out_lane_sat_d;
      out_sat_q      <= out_sat_d;
      sat_q          <= sat_d;
    end
  end

  assign in_ready     = adv;
  assign out_valid    = out_valid_q;
  assign out_vrt      = out_vrt_q;
  assign out_lane_sat = out_lane_sat_q;
  assign out_sat      = out_sat_q;
  assign sat_sticky   = sat_q;

endmodule

// File: tb/tb_vsfx_vadds_pipe.sv
// Randomised bench for vsfx_vadds_pipe against an arithmetic
// per-element saturation model with an in-order scoreboard.
module tb_vsfx_vadds_pipe;

  localparam int VW = 128;
  localparam int NL = VW / 8;

  typedef struct packed {
    logic [VW-1:0] v;
    logic [NL-1:0] f;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vra;
  logic [VW-1:0] in_vrb;
  logic [1:0]    in_esz;
  logic          in_sgn;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vrt;
  logic [NL-1:0] out_lane_sat;
  logic          out_sat;
  logic          sat_clr;
  logic          sat_sticky;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc   = 0;
  int   ready_mode = 0;
  int   stall_at = -100;
  int   stall_n  = 0;
  logic saw_low  = 1'b0;
  exp_t q[$];

  vsfx_vadds_pipe #(.VEC_W(VW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vra       (in_vra),
    .in_vrb       (in_vrb),
    .in_esz       (in_esz),
    .in_sgn       (in_sgn),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vrt      (out_vrt),
    .out_lane_sat (out_lane_sat),
    .out_sat      (out_sat),
    .sat_clr      (sat_clr),
    .sat_sticky   (sat_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [NL-1:0] got,
                       input logic [NL-1:0] exp);
    chk(nm, VW'(got), VW'(exp));
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    chk(nm, VW'(got), VW'(exp));
  endtask

  // Saturating arithmetic per element, straight from the rules.
  function automatic exp_t model(input logic [VW-1:0] a,
                                 input logic [VW-1:0] b,
                                 input logic [1:0] esz,
                                 input logic sgn, input logic sub);
    exp_t   r;
    int     w;
    longint mask, ea, eb, x, lo, hi;
    logic   fl;
    r    = '0;
    w    = (esz == 2'd3) ? 32 : (8 << esz);
    mask = (longint'(1) << w) - 1;
    lo   = sgn ? -(longint'(1) << (w - 1)) : 0;
    hi   = sgn ? (longint'(1) << (w - 1)) - 1 : mask;
    for (int e = 0; e < VW / w; e++) begin
      ea = longint'(a >> (e * w)) & mask;
      eb = longint'(b >> (e * w)) & mask;
      if (sgn && ea[w-1]) ea = ea - (mask + 1);
      if (sgn && eb[w-1]) eb = eb - (mask + 1);
      x  = sub ? ea - eb : ea + eb;
      fl = 1'b0;
      if (x > hi) begin
        x  = hi;
        fl = 1'b1;
      end else if (x < lo) begin
        x  = lo;
        fl = 1'b1;
      end
      r.v = r.v | (VW'(x & mask) << (e * w));
      if (fl)
        for (int k = 0; k < w / 8; k++) r.f[e * (w / 8) + k] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ready_mode == 2) begin
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 7) == 0);
    end else if (ready_mode == 1) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_n);
    end
  endtask

  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [1:0] esz, input logic sgn,
                      input logic sub);
    int n;
    in_vra   = a;
    in_vrb   = b;
    in_esz   = esz;
    in_sgn   = sgn;
    in_sub   = sub;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      tick();
      n++;
      if (n >= 60) begin
        chk1("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    tick();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk1("drain_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    logic [31:0]   w;
    logic [7:0]    by;
    v = '0;
    for (int i = 0; i < VW / 32; i++) begin
      by = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 6))
        0: w = 32'h7FFF_FFFF;
        1: w = 32'h8000_0000;
        2: w = 32'hFFFF_FFFF;
        3: w = {4{by}};
        4: w = {2{8'h80, by}};
        default: w = $urandom;
      endcase
      v[32*i+:32] = w;
    end
    return v;
  endfunction

  initial begin : mon
    exp_t          e;
    logic          stall_prev;
    logic          hs_sat;
    logic          exp_sticky;
    logic [VW-1:0] prev_vrt;
    logic [NL-1:0] prev_f;
    stall_prev = 1'b0;
    exp_sticky = 1'b0;
    prev_vrt   = '0;
    prev_f     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_sticky = 1'b0;
        stall_prev = 1'b0;
      end else begin
        chk1("in_ready", in_ready, !out_valid | out_ready);
        chk1("sat_sticky", sat_sticky, exp_sticky);
        if (!in_ready) saw_low = 1'b1;
        if (stall_prev) begin
          chk("stall_vrt", out_vrt, prev_vrt);
          chk16("stall_flags", out_lane_sat, prev_f);
        end
        hs_sat = 1'b0;
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            chk1("spurious_out", 1'b1, 1'b0);
          end else begin
            e = q.pop_front();
            chk("out_vrt", out_vrt, e.v);
            chk16("out_lane_sat", out_lane_sat, e.f);
            chk1("out_sat", out_sat, |e.f);
            hs_sat = |e.f;
          end
        end
        if (hs_sat) exp_sticky = 1'b1;
        else if (sat_clr) exp_sticky = 1'b0;
        if (in_valid && in_ready)
          q.push_back(model(in_vra, in_vrb, in_esz, in_sgn, in_sub));
        stall_prev = out_valid & !out_ready;
        prev_vrt   = out_vrt;
        prev_f     = out_lane_sat;
      end
    end
  end

  initial begin : main
    exp_t m;
    int   n0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vra    = '0;
    in_vrb    = '0;
    in_esz    = 2'd0;
    in_sgn    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    m = model({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 2'd2, 1'b1, 1'b0);
    chk("pin_w_v", m.v, {4{32'h7FFF_FFFF}});
    chk16("pin_w_f", m.f, 16'hFFFF);
    m = model({16{8'h05}}, {16{8'h10}}, 2'd0, 1'b0, 1'b1);
    chk("pin_b1_v", m.v, '0);
    chk16("pin_b1_f", m.f, 16'hFFFF);
    m = model({16{8'h05}}, {16{8'h03}}, 2'd0, 1'b0, 1'b1);
    chk("pin_b2_v", m.v, {16{8'h02}});
    chk16("pin_b2_f", m.f, 16'h0000);
    m = model({4{16'h8000, 16'h1234}}, {4{16'h0001, 16'h0034}},
              2'd1, 1'b1, 1'b1);
    chk("pin_h_v", m.v, {4{16'h8000, 16'h1200}});
    chk16("pin_h_f", m.f, 16'hCCCC);
    m = model({16{8'hFF}}, {16{8'h01}}, 2'd3, 1'b0, 1'b0);
    chk("pin_r_v", m.v, {16{8'hFF}});

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_vrt", out_vrt, '0);
    chk16("rst_lane_sat", out_lane_sat, '0);
    chk1("rst_out_sat", out_sat, 1'b0);
    chk1("rst_sticky", sat_sticky, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    tick();

    send({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 2'd2, 1'b1, 1'b0);
    drain();
    @(negedge clk);
    chk1("w_sticky", sat_sticky, 1'b1);
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    send({16{8'h05}}, {16{8'h10}}, 2'd0, 1'b0, 1'b1);
    send({16{8'h05}}, {16{8'h03}}, 2'd0, 1'b0, 1'b1);
    send({4{16'h8000, 16'h1234}}, {4{16'h0001, 16'h0034}},
         2'd1, 1'b1, 1'b1);
    drain();

    ready_mode = 1;
    saw_low    = 1'b0;
    n0         = n_out;
    stall_at   = cyc + 3;
    stall_n    = 4;
    for (int i = 0; i < 5; i++)
      send(rvec(), rvec(), 2'(i % 4), 1'(i % 2), 1'(i / 2 % 2));
    drain();
    chk1("bp_in_ready_drop", saw_low, 1'b1);
    chk("bp_count", VW'(n_out - n0), VW'(5));
    ready_mode = 0;
    out_ready  = 1'b1;

    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    @(negedge clk);
    chk1("clr_sticky", sat_sticky, 1'b0);
    tick();
    out_ready = 1'b0;
    send({16{8'h7F}}, {16{8'h7F}}, 2'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    tick();
    sat_clr = 1'b0;
    @(negedge clk);
    chk1("set_wins", sat_sticky, 1'b1);
    tick();
    out_ready = 1'b0;
    send({16{8'h10}}, {16{8'h01}}, 2'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    tick();
    sat_clr = 1'b0;
    @(negedge clk);
    chk1("clr_nonsat", sat_sticky, 1'b0);
    tick();

    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end else begin
        send(rvec(), rvec(), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    drain();
    ready_mode = 0;
    out_ready  = 1'b1;
    sat_clr    = 1'b0;
    tick();

    send({4{32'h8000_0000}}, {4{32'h0000_0001}}, 2'd2, 1'b1, 1'b1);
    drain();
    out_ready = 1'b0;
    send({4{32'h0000_0010}}, {4{32'h0000_0001}}, 2'd2, 1'b1, 1'b0);
    send({4{32'h0000_0020}}, {4{32'h0000_0002}}, 2'd2, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1;
    chk1("pre_rst_valid", out_valid, 1'b1);
    chk1("pre_rst_sticky", sat_sticky, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("async_out_valid", out_valid, 1'b0);
    chk1("async_sticky", sat_sticky, 1'b0);
    chk16("async_lane_sat", out_lane_sat, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    repeat (4) tick();
    chk1("post_rst_no_beats", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
